// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with write-to-read bypass and a per-register
// in-flight write scoreboard that raises RAW/WAW stalls.
// Optional feature macro: REGFILE_SCOREBOARD_STATS_EN adds a saturating
// 16-bit stall_cycles counter output.
module regfile_scoreboard #(
  parameter int DATA_W       = 16,
  parameter int NUM_REGS     = 8,
  parameter int REG_AW       = 3,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rs,
  input  logic [REG_AW-1:0] issue_rt,
  input  logic              issue_rs_used,
  input  logic              issue_rt_used,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              issue_rd_wr,
  output logic              stall,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              sq_valid,
  input  logic [REG_AW-1:0] sq_rd,
  output logic              err
`ifdef REGFILE_SCOREBOARD_STATS_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] CntMax = CW'(MAX_INFLIGHT);
  localparam logic [REG_AW:0] NumRegsW = (REG_AW + 1)'(NUM_REGS);

  function automatic logic inRange(input logic [REG_AW-1:0] sel);
    return {1'b0, sel} < NumRegsW;
  endfunction

  logic [DATA_W-1:0] regFile_q [NUM_REGS];
  logic [CW-1:0]     cnt_q     [NUM_REGS];
  logic [CW-1:0]     cnt_d     [NUM_REGS];
  logic              err_q;
  logic              err_d;

  logic [DATA_W-1:0] rsReg;
  logic [DATA_W-1:0] rtReg;
  logic [CW-1:0]     cntRs;
  logic [CW-1:0]     cntRt;
  logic [CW-1:0]     cntRd;
  logic              resolvingRs;
  logic              resolvingRt;
  logic              decRd;
  logic              accept;
  logic              badSel;

  // Look up register contents and scoreboard counts for the decode selects;
  // out-of-range selects see zero data and an idle counter.
  always_comb begin
    rsReg = '0;
    rtReg = '0;
    cntRs = '0;
    cntRt = '0;
    cntRd = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (issue_rs == REG_AW'(i)) begin
        rsReg = regFile_q[i];
        cntRs = cnt_q[i];
      end
      if (issue_rt == REG_AW'(i)) begin
        rtReg = regFile_q[i];
        cntRt = cnt_q[i];
      end
      if (issue_rd == REG_AW'(i)) begin
        cntRd = cnt_q[i];
      end
    end
    rs_data = (wb_en && wb_sel == issue_rs && inRange(issue_rs)) ? wb_data : rsReg;
    rt_data = (wb_en && wb_sel == issue_rt && inRange(issue_rt)) ? wb_data : rtReg;
  end

  // Hazard detection: a busy source stalls unless its last outstanding write is
  // being bypassed now; a full destination counter stalls unless it drains now.
  always_comb begin
    resolvingRs = wb_en && (wb_sel == issue_rs) && (cntRs == CW'(1));
    resolvingRt = wb_en && (wb_sel == issue_rt) && (cntRt == CW'(1));
    decRd = (wb_en && (wb_sel == issue_rd)) || (sq_valid && (sq_rd == issue_rd));
    stall = issue_valid &&
            ((issue_rs_used && (cntRs != '0) && !resolvingRs) ||
             (issue_rt_used && (cntRt != '0) && !resolvingRt) ||
             (issue_rd_wr && (cntRd == CntMax) && !decRd));
    accept = issue_valid && !stall;
  end

  // Scoreboard next state: net increment/decrement per register with
  // saturation at both ends; any saturation or bad select latches the error.
  always_comb begin
    badSel = (wb_en && !inRange(wb_sel)) ||
             (sq_valid && !inRange(sq_rd)) ||
             (accept && issue_rd_wr && !inRange(issue_rd)) ||
             (issue_valid && issue_rs_used && !inRange(issue_rs)) ||
             (issue_valid && issue_rt_used && !inRange(issue_rt));
    err_d = err_q || badSel;
    for (int i = 0; i < NUM_REGS; i++) begin
      int sum;
      sum = int'(cnt_q[i]);
      if (accept && issue_rd_wr && (issue_rd == REG_AW'(i))) sum = sum + 1;
      if (wb_en && (wb_sel == REG_AW'(i))) sum = sum - 1;
      if (sq_valid && (sq_rd == REG_AW'(i))) sum = sum - 1;
      if (sum < 0) begin
        cnt_d[i] = '0;
        err_d    = 1'b1;
      end else if (sum > MAX_INFLIGHT) begin
        cnt_d[i] = CntMax;
        err_d    = 1'b1;
      end else begin
        cnt_d[i] = CW'(sum);
      end
    end
  end

  // Architectural state: register file, counters and the sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regFile_q[i] <= '0;
        cnt_q[i]     <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wb_en && (wb_sel == REG_AW'(i))) regFile_q[i] <= wb_data;
        cnt_q[i] <= cnt_d[i];
      end
      err_q <= err_d;
    end
  end

  assign err = err_q;

`ifdef REGFILE_SCOREBOARD_STATS_EN
  logic [15:0] stallCycles_q;

  // Count stalled edges, holding at the maximum rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCycles_q <= '0;
    end else if (stall && (stallCycles_q != 16'hFFFF)) begin
      stallCycles_q <= stallCycles_q + 16'd1;
    end
  end

  assign stall_cycles = stallCycles_q;
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: a cycle-by-cycle vector table
// plus hand-written reset, async-reset and (optionally) stall statistics checks.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [2:0]  issue_rs;
  logic [2:0]  issue_rt;
  logic        issue_rs_used;
  logic        issue_rt_used;
  logic [2:0]  issue_rd;
  logic        issue_rd_wr;
  logic        stall;
  logic [15:0] rs_data;
  logic [15:0] rt_data;
  logic        wb_en;
  logic [2:0]  wb_sel;
  logic [15:0] wb_data;
  logic        sq_valid;
  logic [2:0]  sq_rd;
  logic        err;
`ifdef REGFILE_SCOREBOARD_STATS_EN
  logic [15:0] stall_cycles;
`endif

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        iv;
    logic [2:0]  rs;
    logic        rsU;
    logic [2:0]  rt;
    logic        rtU;
    logic [2:0]  rd;
    logic        rdWr;
    logic        wbEn;
    logic [2:0]  wbSel;
    logic [15:0] wbData;
    logic        sqV;
    logic [2:0]  sqRd;
    logic        expStall;
    logic [15:0] expRs;
    logic [15:0] expRt;
    logic        expErr;
  } vec_t;

  vec_t vecs[$];

  regfile_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_rs     (issue_rs),
    .issue_rt     (issue_rt),
    .issue_rs_used(issue_rs_used),
    .issue_rt_used(issue_rt_used),
    .issue_rd     (issue_rd),
    .issue_rd_wr  (issue_rd_wr),
    .stall        (stall),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .wb_en        (wb_en),
    .wb_sel       (wb_sel),
    .wb_data      (wb_data),
    .sq_valid     (sq_valid),
    .sq_rd        (sq_rd),
    .err          (err)
`ifdef REGFILE_SCOREBOARD_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input logic iv, input logic [2:0] rs, input logic rsU,
                        input logic [2:0] rt, input logic rtU, input logic [2:0] rd,
                        input logic rdWr, input logic wbEn, input logic [2:0] wbSel,
                        input logic [15:0] wbData, input logic sqV, input logic [2:0] sqRd,
                        input logic expStall, input logic [15:0] expRs,
                        input logic [15:0] expRt, input logic expErr);
    vec_t v;
    v.iv = iv; v.rs = rs; v.rsU = rsU; v.rt = rt; v.rtU = rtU; v.rd = rd; v.rdWr = rdWr;
    v.wbEn = wbEn; v.wbSel = wbSel; v.wbData = wbData; v.sqV = sqV; v.sqRd = sqRd;
    v.expStall = expStall; v.expRs = expRs; v.expRt = expRt; v.expErr = expErr;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs just after the falling edge, then let them settle.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    issue_valid   = v.iv;
    issue_rs      = v.rs;
    issue_rs_used = v.rsU;
    issue_rt      = v.rt;
    issue_rt_used = v.rtU;
    issue_rd      = v.rd;
    issue_rd_wr   = v.rdWr;
    wb_en         = v.wbEn;
    wb_sel        = v.wbSel;
    wb_data       = v.wbData;
    sq_valid      = v.sqV;
    sq_rd         = v.sqRd;
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic expStall, input logic [15:0] expRs,
                             input logic [15:0] expRt, input logic expErr);
    compared += 4;
    if (stall !== expStall) begin
      mismatched++;
      $display("[TB] FAIL %s stall: got %0b, expected %0b", tag, stall, expStall);
    end
    if (rs_data !== expRs) begin
      mismatched++;
      $display("[TB] FAIL %s rs_data: got %h, expected %h", tag, rs_data, expRs);
    end
    if (rt_data !== expRt) begin
      mismatched++;
      $display("[TB] FAIL %s rt_data: got %h, expected %h", tag, rt_data, expRt);
    end
    if (err !== expErr) begin
      mismatched++;
      $display("[TB] FAIL %s err: got %0b, expected %0b", tag, err, expErr);
    end
  endtask

  task automatic idleVec(output vec_t v);
    v = '{default: '0};
  endtask

  initial begin
    vec_t v;

    // Cycle table: iv rs rsU rt rtU rd rdWr | wbEn wbSel wbData | sqV sqRd | stall rs rt err
    // Bypass: claim r3, then write it back while reading it on both ports.
    addVec(1, 0, 0, 0, 0, 3, 1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0);
    addVec(0, 3, 0, 3, 0, 0, 0, 1, 3, 16'hBEEF, 0, 0, 0, 16'hBEEF, 16'hBEEF, 0);
    addVec(0, 3, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'hBEEF, 16'h0000, 0);
    // RAW on rs: three stalled cycles, then resolved by a bypassed writeback.
    addVec(1, 0, 0, 0, 0, 2, 1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0);
    addVec(1, 2, 1, 3, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'hBEEF, 0);
    addVec(1, 2, 1, 3, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'hBEEF, 0);
    addVec(1, 2, 1, 3, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'hBEEF, 0);
    addVec(1, 2, 1, 3, 0, 0, 0, 1, 2, 16'h1234, 0, 0, 0, 16'h1234, 16'hBEEF, 0);
    addVec(0, 2, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h1234, 16'h0000, 0);
    // RAW on rt; an unused busy source must not stall.
    addVec(1, 0, 0, 0, 0, 1, 1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0);
    addVec(1, 1, 0, 1, 1, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'h0000, 0);
    addVec(1, 1, 0, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0);
    addVec(0, 0, 0, 1, 0, 0, 0, 1, 1, 16'h0055, 0, 0, 0, 16'h0000, 16'h0055, 0);
    // WAW saturation on r5.
    addVec(1, 0, 0, 0, 0, 5, 1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0);
    addVec(1, 0, 0, 0, 0, 5, 1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0);
    addVec(1, 0, 0, 0, 0, 5, 1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0);
    addVec(1, 0, 0, 0, 0, 5, 1, 0, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'h0000, 0);
    addVec(1, 0, 0, 0, 0, 5, 1, 1, 5, 16'hAAAA, 0, 0, 0, 16'h0000, 16'h0000, 0);
    addVec(1, 5, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 16'hAAAA, 16'h0000, 0);
    addVec(1, 5, 0, 0, 0, 5, 1, 0, 0, 16'h0000, 0, 0, 1, 16'hAAAA, 16'h0000, 0);
    // Drain r5: only the final outstanding write resolves a RAW stall.
    addVec(0, 5, 0, 0, 0, 0, 0, 1, 5, 16'h0001, 0, 0, 0, 16'h0001, 16'h0000, 0);
    addVec(1, 5, 1, 0, 0, 0, 0, 1, 5, 16'h0002, 0, 0, 1, 16'h0002, 16'h0000, 0);
    addVec(1, 5, 1, 0, 0, 0, 0, 1, 5, 16'h0003, 0, 0, 0, 16'h0003, 16'h0000, 0);
    // Squash retires r4 without writing it.
    addVec(1, 0, 0, 0, 0, 4, 1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0);
    addVec(1, 4, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 4, 1, 16'h0000, 16'h0000, 0);
    addVec(1, 4, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0);
    // Writeback and squash of r6 in one cycle subtract two.
    addVec(1, 0, 0, 0, 0, 6, 1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0);
    addVec(1, 0, 0, 0, 0, 6, 1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0);
    addVec(1, 6, 1, 0, 0, 0, 0, 1, 6, 16'h0066, 1, 6, 1, 16'h0066, 16'h0000, 0);
    addVec(1, 6, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0066, 16'h0000, 0);
    // Squash underflow on idle r7: err next edge, sticky, counter held at 0.
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 7, 0, 16'h0000, 16'h0000, 0);
    addVec(1, 7, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1);
    addVec(0, 3, 0, 2, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'hBEEF, 16'h1234, 1);

    // Hold reset for two cycles with quiet inputs.
    rst = 1'b1;
    idleVec(v);
    applyStimulus(v);
    applyStimulus(v);
    @(negedge clk);
    rst = 1'b0;

    // Every register reads zero after reset, with no stall or error.
    for (int i = 0; i < 8; i++) begin
      idleVec(v);
      v.rs = 3'(i);
      v.rt = 3'(7 - i);
      applyStimulus(v);
      checkOutput($sformatf("reset_read%0d", i), 1'b0, 16'h0000, 16'h0000, 1'b0);
    end

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].expStall, vecs[i].expRs,
                  vecs[i].expRt, vecs[i].expErr);
    end

    // Asynchronous reset mid-cycle clears err and the register file at once.
    @(negedge clk);
    issue_valid = 1'b0;
    issue_rs    = 3'd3;
    issue_rt    = 3'd6;
    rst         = 1'b1;
    #1;
    checkOutput("async_reset", 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    rst = 1'b0;

`ifdef REGFILE_SCOREBOARD_STATS_EN
    // Five stalled edges on a RAW to r0 yield a stall count of five.
    idleVec(v);
    v.iv = 1'b1; v.rd = 3'd0; v.rdWr = 1'b1;
    applyStimulus(v);
    checkOutput("stats_issue", 1'b0, 16'h0000, 16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idleVec(v);
      v.iv = 1'b1; v.rs = 3'd0; v.rsU = 1'b1;
      applyStimulus(v);
      checkOutput($sformatf("stats_stall%0d", i), 1'b1, 16'h0000, 16'h0000, 1'b0);
    end
    idleVec(v);
    applyStimulus(v);
    compared++;
    if (stall_cycles !== 16'd5) begin
      mismatched++;
      $display("[TB] FAIL stall_cycles: got %0d, expected 5", stall_cycles);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the decode-stage register file with write-to-read bypass.
- Adds a per-register in-flight write scoreboard, so decode can raise a RAW/WAW stall itself instead of relying on external NOP insertion.
- Sits in decode: read ports feed the ID/EX latch, the write port is driven from writeback, and a squash port retires killed instructions.

Parameters:
- DATA_W, 16, register data width in bits.
- NUM_REGS, 8, number of architectural registers (all general purpose, none hardwired).
- REG_AW, 3, register select width; must satisfy 2^REG_AW >= NUM_REGS.
- MAX_INFLIGHT, 3, maximum outstanding writes tracked per register; counter width CW = clog2(MAX_INFLIGHT+1).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous reset, active-high.
- issue_valid  in  1  decode holds a valid instruction this cycle.
- issue_rs  in  REG_AW  source register 1 select.
- issue_rt  in  REG_AW  source register 2 select.
- issue_rs_used  in  1  instruction reads rs.
- issue_rt_used  in  1  instruction reads rt.
- issue_rd  in  REG_AW  destination register select.
- issue_rd_wr  in  1  instruction writes rd.
- stall  out  1  combinational; instruction must not issue this cycle.
- rs_data  out  DATA_W  combinational read of issue_rs, with bypass.
- rt_data  out  DATA_W  combinational read of issue_rt, with bypass.
- wb_en  in  1  writeback write enable.
- wb_sel  in  REG_AW  writeback destination.
- wb_data  in  DATA_W  writeback data.
- sq_valid  in  1  an issued, register-writing instruction was squashed and will never write back.
- sq_rd  in  REG_AW  destination of the squashed instruction.
- err  out  1  registered, sticky error flag.

Behaviour:
- Reset, asynchronous on rst high: all registers 0, all counters 0, err 0. stall is then 0 unless a source is busy, which cannot occur after reset.
- Register write: on a clock edge with wb_en=1 and wb_sel<NUM_REGS, reg[wb_sel] <= wb_data.
- Read path is combinational:
  - rs_data = wb_data if wb_en and wb_sel==issue_rs; otherwise reg[issue_rs].
  - rt_data follows the same rule with issue_rt.
  - A select >= NUM_REGS reads 0.
- busy(r) = cnt[r] != 0.
- resolving(r) = wb_en and wb_sel==r and cnt[r]==1, meaning the last outstanding write lands this cycle and is bypassed.
- stall = issue_valid AND any of:
  - issue_rs_used and busy(rs) and not resolving(rs);
  - issue_rt_used and busy(rt) and not resolving(rt);
  - issue_rd_wr and cnt[rd]==MAX_INFLIGHT and not (a decrement of rd this cycle).
- Issue accepted = issue_valid and not stall. When accepted with issue_rd_wr=1, it increments cnt[rd].
- Decrement events:
  - wb_en, which decrements cnt[wb_sel];
  - sq_valid, which decrements cnt[sq_rd].
- Counter update per register r, per edge: next = cnt + inc(r) - dec_wb(r) - dec_sq(r). Increment and decrement of the same register in one cycle leaves it unchanged. Two decrements to one register in one cycle subtract 2.
- Underflow: a decrement that would take the counter below 0 saturates it at 0 and sets err.
- Overflow cannot occur by construction. If forced, the counter saturates at MAX_INFLIGHT and sets err.
- Any select >= NUM_REGS on an active port sets err. The event is otherwise ignored: no write and no counter change.
- err clears only on rst.
- Latency:
  - Register data is visible one cycle after the write edge, or the same cycle via bypass.
  - stall has zero latency relative to the inputs.
- No internal state machine beyond the counters; the block holds no pending issue. Upstream holds the instruction while stall=1.

Optional Feature:
- Macro: REGFILE_SCOREBOARD_STATS_EN.
- When defined:
  - adds output port stall_cycles (16 bits);
  - stall_cycles increments on every edge where stall=1, saturates at 16'hFFFF, and resets to 0 on rst.
- When undefined: the port and counter are absent, and the rest of the behaviour is identical.

Test Plan:
- Reset, then read every register: rst pulse; issue_rs=0..7 -> rs_data=16'h0000, stall=0, err=0.
- Bypass: wb_en=1, wb_sel=3, wb_data=16'hBEEF, with issue_rs=3 in the same cycle -> rs_data=16'hBEEF that cycle; next cycle reg[3] reads 16'hBEEF.
- RAW stall and resolve:
  - issue rd=2 (accepted); next cycle issue rs=2, rs_used=1 -> stall=1 for 3 cycles with no writeback;
  - wb_en, wb_sel=2, wb_data=16'h1234 -> stall=0, rs_data=16'h1234 that cycle.
- WAW saturation: issue rd=5 three times with no writeback; the 4th issue rd=5 -> stall=1. A simultaneous wb_sel=5 -> stall=0, accepted, and cnt[5] stays at 3.
- Squash: issue rd=4; sq_valid=1, sq_rd=4 the next cycle -> a following read of rs=4 does not stall, and reg[4] is unchanged.
- Error: sq_valid=1, sq_rd=6 with cnt[6]=0 -> err=1 next edge and stays 1 until rst. With stats enabled: 5 forced stall cycles -> stall_cycles=5.
